// File: rtl/down_timer_pkg.sv
// down_timer_pkg -- shared types and constants for the down_timer16 block.
// Contents: FSM state encoding, datapath Q-select encoding, default width.
// No logic; imported by down_timer16 and down_timer16_ctrl.

package down_timer_pkg;

  // Default counter / reload register width in bits.
  localparam int DEFAULT_WIDTH = 16;

  // Controller state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Next-value select for the Q register.
  typedef enum logic [1:0] {
    QSEL_HOLD   = 2'd0,  // keep current Q
    QSEL_LOAD   = 2'd1,  // Q <= D
    QSEL_RELOAD = 2'd2,  // Q <= R
    QSEL_DEC    = 2'd3   // Q <= Q - 1
  } qsel_t;

endpackage : down_timer_pkg

// File: rtl/down_timer16_ctrl.sv
// down_timer16_ctrl -- FSM for the down timer: next-state, expiry detect, TC pulse.
// Ports: i_clk/i_rst (sync, active-high), i_ld/i_stop/i_start/i_ce/i_mode controls,
//        i_q_zero (Q==0 from datapath); o_q_sel (Q mux select), o_tc (registered), o_busy.

module down_timer16_ctrl
  import down_timer_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_ld,
  input  logic  i_stop,
  input  logic  i_start,
  input  logic  i_ce,
  input  logic  i_mode,
  input  logic  i_q_zero,
  output qsel_t o_q_sel,
  output logic  o_tc,
  output logic  o_busy
);

  state_t r_state;
  state_t w_state_nxt;
  logic   r_tc;
  logic   w_expiry;

  // An expiry is a counting edge in RUN that finds Q already at zero.
  // LD, STOP and START all outrank CE, so any of them suppresses it.
  assign w_expiry = (r_state == RUN) && !i_ld && !i_stop && !i_start &&
                    i_ce && i_q_zero;

  // ---------------------------------------------------------------
  // State register (plus the registered TC pulse)
  // ---------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_tc    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tc    <= w_expiry;
    end
  end

  // ---------------------------------------------------------------
  // Next-state logic. Priority: LD > STOP > START > CE.
  // STOP consumes the edge in every state, but only leaves RUN.
  // ---------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    if (i_ld) begin
      w_state_nxt = IDLE;
    end else if (i_stop) begin
      if (r_state == RUN) w_state_nxt = IDLE;
    end else if (i_start) begin
      w_state_nxt = RUN;
    end else if (w_expiry && !i_mode) begin
      // MODE is only looked at here: one-shot parks in DONE.
      w_state_nxt = DONE;
    end
  end

  // ---------------------------------------------------------------
  // Output logic: datapath select for Q.
  // ---------------------------------------------------------------
  always_comb begin
    o_q_sel = QSEL_HOLD;
    if (i_ld) begin
      o_q_sel = QSEL_LOAD;
    end else if (i_stop) begin
      o_q_sel = QSEL_HOLD;
    end else if (i_start) begin
      // From IDLE, START resumes with the held Q; from RUN/DONE it restarts from R.
      o_q_sel = (r_state == IDLE) ? QSEL_HOLD : QSEL_RELOAD;
    end else if (i_ce && (r_state == RUN)) begin
      if (!i_q_zero)   o_q_sel = QSEL_DEC;
      else if (i_mode) o_q_sel = QSEL_RELOAD;
      else             o_q_sel = QSEL_HOLD;   // one-shot: stay at 0
    end
  end

  assign o_tc   = r_tc;
  assign o_busy = (r_state == RUN);

endmodule : down_timer16_ctrl

// File: rtl/down_timer16.sv
// down_timer16 -- loadable down counter with one-shot / periodic auto-reload and TC pulse.
// Ports: CLK, RST (sync, active-high), LD/CE/START/STOP/MODE controls, D load value;
//        Q registered count, TC registered one-cycle terminal-count pulse, BUSY (state==RUN).

module down_timer16
  import down_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LD,
  input  logic             CE,
  input  logic             START,
  input  logic             STOP,
  input  logic             MODE,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             BUSY
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_reload;
  logic             w_q_zero;
  qsel_t            w_q_sel;

  assign w_q_zero = (r_q == '0);

  down_timer16_ctrl u_ctrl (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_ld     (LD),
    .i_stop   (STOP),
    .i_start  (START),
    .i_ce     (CE),
    .i_mode   (MODE),
    .i_q_zero (w_q_zero),
    .o_q_sel  (w_q_sel),
    .o_tc     (TC),
    .o_busy   (BUSY)
  );

  // Reload register: written only by LD.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_reload <= '0;
    end else if (LD) begin
      r_reload <= D;
    end
  end

  // Count register. The controller never selects DEC with Q==0,
  // so Q cannot wrap below zero.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q <= '0;
    end else begin
      case (w_q_sel)
        QSEL_LOAD:   r_q <= D;
        QSEL_RELOAD: r_q <= r_reload;
        QSEL_DEC:    r_q <= r_q - WIDTH'(1);
        default:     r_q <= r_q;
      endcase
    end
  end

  assign Q = r_q;

endmodule : down_timer16

// File: tb/tb_down_timer16.sv
// tb_down_timer16 -- directed bench for down_timer16.
// Drives inputs 1ns after each rising edge and samples outputs there too.
// Each task checks {Q,TC,BUSY} against hand-computed values.

module tb_down_timer16;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        LD = 1'b0;
  logic        CE = 1'b0;
  logic        START = 1'b0;
  logic        STOP = 1'b0;
  logic        MODE = 1'b0;
  logic [15:0] D = 16'h0;
  logic [15:0] Q;
  logic        TC;
  logic        BUSY;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [17:0] exp_v;

  always #5 CLK = ~CLK;

  down_timer16 #(.WIDTH(16)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .LD    (LD),
    .CE    (CE),
    .START (START),
    .STOP  (STOP),
    .MODE  (MODE),
    .D     (D),
    .Q     (Q),
    .TC    (TC),
    .BUSY  (BUSY)
  );

  // Apply one set of inputs for exactly one rising edge, then settle 1ns.
  task automatic cyc(input logic rst, input logic ld, input logic start,
                     input logic stop, input logic ce, input logic mode,
                     input logic [15:0] d);
    RST = rst; LD = ld; START = start; STOP = stop; CE = ce; MODE = mode; D = d;
    @(posedge CLK);
    #1;
  endtask

  // cyc argument order: rst, ld, start, stop, ce, mode, d

  task automatic test_reset;
    cyc(1, 0, 0, 0, 0, 0, 16'h0);
    exp_v = {16'h0000, 1'b0, 1'b0};
    if ({Q, TC, BUSY} !== exp_v) begin n_fail++; $display("FAIL reset_state got=%h exp=%h", {Q, TC, BUSY}, exp_v); end
    n_tests++;
    // Bring the count to 0x0123 in RUN, then reset mid-count.
    cyc(0, 1, 0, 0, 0, 0, 16'h0123);
    cyc(0, 0, 1, 0, 0, 0, 16'h0);
    exp_v = {16'h0123, 1'b0, 1'b1};
    if ({Q, TC, BUSY} !== exp_v) begin n_fail++; $display("FAIL reset_pre_run got=%h exp=%h", {Q, TC, BUSY}, exp_v); end
    n_tests++;
    cyc(1, 0, 0, 0, 1, 0, 16'h0);
    exp_v = {16'h0000, 1'b0, 1'b0};
    if ({Q, TC, BUSY} !== exp_v) begin n_fail++; $display("FAIL reset_mid_count got=%h exp=%h", {Q, TC, BUSY}, exp_v); end
    n_tests++;
    // R was cleared: START then one CE edge expires immediately.
    cyc(0, 0, 1, 0, 0, 0, 16'h0);
    cyc(0, 0, 0, 0, 1, 0, 16'h0);
    exp_v = {16'h0000, 1'b1, 1'b0};
    if ({Q, TC, BUSY} !== exp_v) begin n_fail++; $display("FAIL reset_r_zero_expiry got=%h exp=%h", {Q, TC, BUSY}, exp_v); end
    n_tests++;
    cyc(0, 0, 0, 0, 0, 0, 16'h0);
    exp_v = {16'h0000, 1'b0, 1'b0};
    if ({Q, TC, BUSY} !== exp_v) begin n_fail++; $display("FAIL reset_tc_one_cycle got=%h exp=%h", {Q, TC, BUSY}, exp_v); end
    n_tests++;
  endtask

  task automatic test_oneshot;
    cyc(0, 1, 0, 0, 0, 0, 16'd3);
    exp_v = {16'd3, 1'b0, 1'b0};
    if ({Q, TC, BUSY} !== exp_v) begin n_fail++; $display("FAIL oneshot_load got=%h exp=%h", {Q, TC, BUSY}, exp_v); end
    n_tests++;
    cyc(0, 0, 1, 0, 0, 0, 16'd0);
    exp_v = {16'd3, 1'b0, 1'b1};
    if ({Q, TC, BUSY} !== exp_v) begin n_fail++; $display("FAIL oneshot_start got=%h exp=%h", {Q, TC, BUSY}, exp_v); end
    n_tests++;
    for (int k = 1; k <= 3; k++) begin
      cyc(0, 0, 0, 0, 1, 0, 16'd0);
      exp_v = {16'(3 - k), 1'b0, 1'b1};
      if ({Q, TC, BUSY} !== exp_v) begin n_fail++; $display("FAIL oneshot_count%0d got=%h exp=%h", k, {Q, TC, BUSY}, exp_v); end
      n_tests++;
    end
    cyc(0, 0, 0, 0, 1, 0, 16'd0);
    exp_v = {16'd0, 1'b1, 1'b0};
    if ({Q, TC, BUSY} !== exp_v) begin n_fail++; $display("FAIL oneshot_expire got=%h exp=%h", {Q, TC, BUSY}, exp_v); end
    n_tests++;
    cyc(0, 0, 0, 0, 1, 0, 16'd0);
    exp_v = {16'd0, 1'b0, 1'b0};
    if ({Q, TC, BUSY} !== exp_v) begin n_fail++; $display("FAIL oneshot_done_hold got=%h exp=%h", {Q, TC, BUSY}, exp_v); end
    n_tests++;
    // START from DONE reloads R and runs again.
    cyc(0, 0, 1, 0, 0, 0, 16'd0);
    exp_v = {16'd3, 1'b0, 1'b1};
    if ({Q, TC, BUSY} !== exp_v) begin n_fail++; $display("FAIL oneshot_done_restart got=%h exp=%h", {Q, TC, BUSY}, exp_v); end
    n_tests++;
  endtask

  task automatic test_periodic;
    cyc(0, 1, 0, 0, 0, 1, 16'd2);
    cyc(0, 0, 1, 0, 0, 1, 16'd0);
    // Q after enabled edge k: 1,0,2,1,0,2,... ; TC high after every 3rd edge.
    for (int k = 1; k <= 12; k++) begin
      cyc(0, 0, 0, 0, 1, 1, 16'd0);
      exp_v = {16'(2 - (k % 3)), (k % 3) == 0, 1'b1};
      if ({Q, TC, BUSY} !== exp_v) begin n_fail++; $display("FAIL periodic_edge%0d got=%h exp=%h", k, {Q, TC, BUSY}, exp_v); end
      n_tests++;
    end
  endtask

  task automatic test_stop_restart;
    cyc(0, 1, 0, 0, 0, 0, 16'd7);
    cyc(0, 0, 1, 0, 0, 0, 16'd0);
    cyc(0, 0, 0, 0, 1, 0, 16'd0);
    cyc(0, 0, 0, 0, 1, 0, 16'd0);
    exp_v = {16'd5, 1'b0, 1'b1};
    if ({Q, TC, BUSY} !== exp_v) begin n_fail++; $display("FAIL stop_pre got=%h exp=%h", {Q, TC, BUSY}, exp_v); end
    n_tests++;
    cyc(0, 0, 0, 1, 1, 0, 16'd0);   // STOP outranks CE
    exp_v = {16'd5, 1'b0, 1'b0};
    if ({Q, TC, BUSY} !== exp_v) begin n_fail++; $display("FAIL stop_hold got=%h exp=%h", {Q, TC, BUSY}, exp_v); end
    n_tests++;
    cyc(0, 0, 1, 0, 0, 0, 16'd0);   // resume from IDLE keeps Q
    cyc(0, 0, 0, 0, 1, 0, 16'd0);
    exp_v = {16'd4, 1'b0, 1'b1};
    if ({Q, TC, BUSY} !== exp_v) begin n_fail++; $display("FAIL stop_resume got=%h exp=%h", {Q, TC, BUSY}, exp_v); end
    n_tests++;
    cyc(0, 1, 1, 0, 1, 0, 16'hFFFF); // LD wins over START and CE
    exp_v = {16'hFFFF, 1'b0, 1'b0};
    if ({Q, TC, BUSY} !== exp_v) begin n_fail++; $display("FAIL ld_priority got=%h exp=%h", {Q, TC, BUSY}, exp_v); end
    n_tests++;
    cyc(0, 0, 0, 0, 1, 0, 16'd0);   // CE in IDLE does nothing
    exp_v = {16'hFFFF, 1'b0, 1'b0};
    if ({Q, TC, BUSY} !== exp_v) begin n_fail++; $display("FAIL idle_ce_ignored got=%h exp=%h", {Q, TC, BUSY}, exp_v); end
    n_tests++;
    cyc(0, 0, 1, 0, 0, 0, 16'd0);
    cyc(0, 0, 0, 0, 1, 0, 16'd0);
    cyc(0, 0, 1, 0, 1, 0, 16'd0);   // restart in RUN: Q <= R, no decrement
    exp_v = {16'hFFFF, 1'b0, 1'b1};
    if ({Q, TC, BUSY} !== exp_v) begin n_fail++; $display("FAIL run_restart got=%h exp=%h", {Q, TC, BUSY}, exp_v); end
    n_tests++;
  endtask

  task automatic test_ce_toggle;
    logic [17:0] tab [10];
    tab[0] = {16'd3, 1'b0, 1'b1};
    tab[1] = {16'd3, 1'b0, 1'b1};
    tab[2] = {16'd2, 1'b0, 1'b1};
    tab[3] = {16'd2, 1'b0, 1'b1};
    tab[4] = {16'd1, 1'b0, 1'b1};
    tab[5] = {16'd1, 1'b0, 1'b1};
    tab[6] = {16'd0, 1'b0, 1'b1};
    tab[7] = {16'd0, 1'b0, 1'b1};
    tab[8] = {16'd0, 1'b1, 1'b0};   // 5th enabled edge
    tab[9] = {16'd0, 1'b0, 1'b0};
    cyc(0, 1, 0, 0, 0, 0, 16'd4);
    cyc(0, 0, 1, 0, 0, 0, 16'd0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0, (i % 2) == 0, 0, 16'd0);
      if ({Q, TC, BUSY} !== tab[i]) begin n_fail++; $display("FAIL ce_toggle_edge%0d got=%h exp=%h", i, {Q, TC, BUSY}, tab[i]); end
      n_tests++;
    end
  endtask

  task automatic test_zero_periodic;
    cyc(0, 1, 0, 0, 0, 1, 16'd0);
    cyc(0, 0, 1, 0, 0, 1, 16'd0);
    for (int k = 1; k <= 5; k++) begin
      cyc(0, 0, 0, 0, 1, 1, 16'd0);
      exp_v = {16'd0, 1'b1, 1'b1};
      if ({Q, TC, BUSY} !== exp_v) begin n_fail++; $display("FAIL zero_periodic_edge%0d got=%h exp=%h", k, {Q, TC, BUSY}, exp_v); end
      n_tests++;
    end
    cyc(0, 0, 0, 0, 0, 1, 16'd0);
    exp_v = {16'd0, 1'b0, 1'b1};
    if ({Q, TC, BUSY} !== exp_v) begin n_fail++; $display("FAIL zero_periodic_ce_off got=%h exp=%h", {Q, TC, BUSY}, exp_v); end
    n_tests++;
  endtask

  task automatic test_mode_at_expiry;
    // Loaded one-shot, MODE flipped to periodic before expiry: reloads.
    cyc(0, 1, 0, 0, 0, 0, 16'd1);
    cyc(0, 0, 1, 0, 0, 0, 16'd0);
    cyc(0, 0, 0, 0, 1, 0, 16'd0);
    cyc(0, 0, 0, 0, 1, 1, 16'd0);
    exp_v = {16'd1, 1'b1, 1'b1};
    if ({Q, TC, BUSY} !== exp_v) begin n_fail++; $display("FAIL mode_sampled_at_expiry got=%h exp=%h", {Q, TC, BUSY}, exp_v); end
    n_tests++;
  endtask

  initial begin
    test_reset;
    test_oneshot;
    test_periodic;
    test_stop_restart;
    test_ce_toggle;
    test_zero_periodic;
    test_mode_at_expiry;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_down_timer16
